// File: rtl/fir_decim_requant.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decim_requant
//  Purpose  : Decimates a 32-bit filter accumulator stream by DEC, requantizes
//             each kept sample to 16 bits (arithmetic shift by SHIFT, then
//             saturation) and buffers results in a DEPTH-entry output FIFO
//             with sticky saturation / overflow flags.
//  Options  : FIR_DECIM_ROUND_EN - when defined, round half up before the
//             shift; otherwise truncate toward minus infinity.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_decim_requant #(
  parameter int DEC   = 2,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic signed [31:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic [4:0]         level,
  output logic               sat_flag,
  output logic               ovf_flag
);

  localparam int         PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] PHASE_LAST = 4'(DEC - 1);
  localparam logic [4:0] LEVEL_FULL = 5'(DEPTH);

  logic [3:0]         phase;
  logic               keep;
  logic signed [32:0] wide;
  logic signed [32:0] q;
  logic signed [15:0] q_sat;
  logic               q_clip;

  logic               stage_valid;
  logic signed [15:0] stage_data;

  logic signed [15:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               wr_drop;

  // Only the first sample of each decimation group is kept.
  assign keep = in_valid && (phase == 4'd0);

  // One extra sign bit so the rounding offset can never overflow.
  assign wide = {in_data[31], in_data};

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  assign q = (wide + HALF) >>> SHIFT;
`else
  assign q = wide >>> SHIFT;
`endif

  // Clamp the shifted value into the 16-bit signed output range.
  always_comb begin
    q_clip = 1'b0;
    q_sat  = q[15:0];
    if (q > 33'sd32767) begin
      q_sat  = 16'sh7FFF;
      q_clip = 1'b1;
    end else if (q < -33'sd32768) begin
      q_sat  = 16'sh8000;
      q_clip = 1'b1;
    end
  end

  // Decimation phase: advances on every input sample, wraps at DEC-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 4'd0;
    end else if (clr) begin
      phase <= 4'd0;
    end else if (in_valid) begin
      phase <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
    end
  end

  // Single pipeline stage holding the requantized kept sample; sat is
  // flagged as soon as a kept sample clips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      sat_flag    <= 1'b0;
    end else if (clr) begin
      stage_valid <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      stage_valid <= keep;
      if (keep) begin
        stage_data <= q_sat;
      end
      if (keep && q_clip) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign full      = (level == LEVEL_FULL);
  assign out_valid = (level != 5'd0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = stage_valid && (!full || pop);
  assign wr_drop   = stage_valid && full && !pop;
  assign out_data  = mem[rd_ptr];

  // FIFO storage; zeroed only by reset so the head never shows unknowns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clr && wr_en) begin
      mem[wr_ptr] <= stage_data;
    end
  end

  // Pointers wrap naturally at DEPTH; level is counted separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= 5'd0;
      ovf_flag <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= 5'd0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        level <= level + 5'd1;
      end else if (pop && !wr_en) begin
        level <= level - 5'd1;
      end
      if (wr_drop) begin
        ovf_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_decim_requant.md
FIR_DECIM_REQUANT -- requirements
Module: fir_decim_requant

Interface
REQ-001 SHALL have parameter DEC, default 2: decimation factor, range 1..16.
REQ-002 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied before saturation, range 1..16.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, range 2..16.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of the datapath and flags.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a new filter output this cycle; there is no backpressure.
REQ-008 SHALL have port in_data, input, 32 bits signed: filter accumulator output.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO head is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-011 SHALL have port out_data, output, 16 bits signed: requantized, decimated sample.
REQ-012 SHALL have port level, output, 5 bits: FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port sat_flag, output, 1 bit: sticky, set when any kept sample saturated.
REQ-014 SHALL have port ovf_flag, output, 1 bit: sticky, set when a kept sample was dropped because the FIFO was full.

Function
REQ-015 SHALL hold a phase counter 0..DEC-1 that advances only on in_valid and wraps from DEC-1 to 0.
REQ-016 SHALL keep the sample accepted while phase==0 and discard all other samples; with DEC=1 every sample is kept.
REQ-017 SHALL compute, for a kept sample, q = in_data >>> SHIFT in at least 33-bit signed arithmetic.
REQ-018 SHALL clamp q to [-32768, 32767] and set sat_flag when clamping occurs.
REQ-019 SHALL register the requantized result in one pipeline stage; stage valid at edge k+1 when in_valid is sampled at edge k.
REQ-020 SHALL write the stage into the FIFO at edge k+2, giving out_valid high after edge k+2 when the FIFO was empty.
REQ-021 SHALL pop the FIFO head on an edge with out_valid && out_ready; out_data SHALL be stable while out_valid && !out_ready.
REQ-022 SHALL accept a write when full only if a pop occurs on the same edge, leaving level unchanged.
REQ-023 SHALL drop the write and set ovf_flag when the FIFO is full with no simultaneous pop; stored data SHALL be unaffected.
REQ-024 SHALL keep the FIFO pointers wrapping modulo DEPTH and SHALL track level independently of the pointers.
REQ-025 SHALL hold out_valid = (level != 0) and SHALL leave out_data undefined-free: the head value is shown when empty.
REQ-026 SHALL, on clr, zero the phase, stage valid, FIFO pointers, level, sat_flag, and ovf_flag on the next edge; clr SHALL take priority over simultaneous in_valid and pop.

Reset
REQ-027 SHALL, while rst_n is low, force phase=0, stage valid=0, level=0, out_valid=0, out_data=0, sat_flag=0, and ovf_flag=0.
REQ-028 SHALL discard data in flight and ignore inputs when reset asserts mid-stream; the first sample after release SHALL be kept (phase 0).

Configuration
REQ-029 SHALL support macro FIR_DECIM_ROUND_EN: when defined, q = (in_data + 2^(SHIFT-1)) >>> SHIFT (round half up) computed without 32-bit overflow; when undefined, q is plain truncation toward minus infinity.

Verification
REQ-030 SHALL cover this case: with DEC=2, SHIFT=8, out_ready=1, in_data = 256, 512, 768, 1024, 1280, 1536 on consecutive cycles -> out_data 1, 3, 5, with the first out_valid two cycles after the first input.
REQ-031 SHALL cover this case: with DEC=1, in_data=4736 -> out_data 18 without the macro, 19 with FIR_DECIM_ROUND_EN; in_data=-384 -> -2 without, -1 with.
REQ-032 SHALL cover this case: in_data=0x7FFFFFFF then 0x80000000 (DEC=1) -> out_data 32767 then -32768, sat_flag=1 until clr.
REQ-033 SHALL cover this case: out_ready=0, DEC=1, 6 consecutive samples -> level=4, ovf_flag=1, then draining yields the first 4 samples in order.
REQ-034 SHALL cover this case: at level=4, simultaneous write and pop -> level stays 4, ovf_flag stays 0, new sample appended.
REQ-035 SHALL cover this case: rst_n pulsed low mid-stream with level=3 -> out_valid=0 and level=0 immediately; the next input is kept and appears two cycles later.
